// File: rtl/regfile_sb_if.sv
// Register-file / scoreboard bus: read ports, writeback port, reserve port and status.
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [WIDTH-1:0] radata;
  logic [WIDTH-1:0] rbdata;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             rsv;
  logic [AW-1:0]    rsv_addr;
  logic             busy_a;
  logic             busy_b;
  logic             hazard;
  logic [AW:0]      busy_cnt;
  logic             err;

  modport master (
    output ra, rb, we, waddr, wdata, rsv, rsv_addr,
    input  radata, rbdata, busy_a, busy_b, hazard, busy_cnt, err
  );

  modport slave (
    input  ra, rb, we, waddr, wdata, rsv, rsv_addr,
    output radata, rbdata, busy_a, busy_b, hazard, busy_cnt, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, two combinational read ports.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             err_q;

  logic             wr_en, rsv_en, same_addr;
  logic             cnt_inc, cnt_dec, err_set;
  logic [WIDTH-1:0] radata_c, rbdata_c;
  logic             busy_a_c, busy_b_c;

  assign wr_en     = bus.we  && (bus.waddr    != '0);
  assign rsv_en    = bus.rsv && (bus.rsv_addr != '0);
  assign same_addr = wr_en && rsv_en && (bus.waddr == bus.rsv_addr);

  // A reservation landing on the register being written back keeps it busy;
  // the count only moves when a bit actually changes value.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[bus.waddr]    = 1'b0;
    if (rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    cnt_inc = rsv_en && !busy_q[bus.rsv_addr];
    cnt_dec = wr_en && busy_q[bus.waddr] && !same_addr;
    err_set = rsv_en && busy_q[bus.rsv_addr] && !same_addr;
    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (wr_en) mem_q[bus.waddr] <= bus.wdata;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    radata_c = (bus.ra == '0) ? '0 : mem_q[bus.ra];
    rbdata_c = (bus.rb == '0) ? '0 : mem_q[bus.rb];
    busy_a_c = busy_q[bus.ra];
    busy_b_c = busy_q[bus.rb];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && (bus.waddr == bus.ra)) begin
      radata_c = bus.wdata;
      if (!(rsv_en && (bus.rsv_addr == bus.ra))) busy_a_c = 1'b0;
    end
    if (wr_en && (bus.waddr == bus.rb)) begin
      rbdata_c = bus.wdata;
      if (!(rsv_en && (bus.rsv_addr == bus.rb))) busy_b_c = 1'b0;
    end
`endif
  end

  assign bus.radata   = radata_c;
  assign bus.rbdata   = rbdata_c;
  assign bus.busy_a   = busy_a_c;
  assign bus.busy_b   = busy_b_c;
  assign bus.hazard   = busy_a_c | busy_b_c;
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: writeback, reservation, hazard, error and reset behaviour.
module tb_regfile_sb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rf ();

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rf.we = 1'b0; rf.rsv = 1'b0; rf.waddr = '0; rf.rsv_addr = '0; rf.wdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rf.ra  = '0;
    rf.rb  = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rf.ra = 5'd5; rf.rb = 5'd7;
    #1;
    check("rst_cnt", rf.busy_cnt, 0);
    check("rst_err", rf.err, 0);
    check("rst_hazard", rf.hazard, 0);
    check("rst_radata", rf.radata, 0);

    // Write and read back, then writes to r0 are dropped
    rf.we = 1'b1; rf.waddr = 5'd5; rf.wdata = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    check("wr5_radata", rf.radata, 32'hDEADBEEF);
    rf.we = 1'b1; rf.waddr = 5'd0; rf.wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    rf.ra = 5'd0;
    #1;
    check("r0_radata", rf.radata, 0);
    check("r0_cnt", rf.busy_cnt, 0);

    // Reserve then writeback
    rf.rsv = 1'b1; rf.rsv_addr = 5'd7;
    tick();
    idle();
    rf.rb = 5'd7;
    #1;
    check("rsv7_busy_b", rf.busy_b, 1);
    check("rsv7_hazard", rf.hazard, 1);
    check("rsv7_cnt", rf.busy_cnt, 1);
    rf.we = 1'b1; rf.waddr = 5'd7; rf.wdata = 32'h77;
    tick();
    idle();
    #1;
    check("wb7_busy_b", rf.busy_b, 0);
    check("wb7_cnt", rf.busy_cnt, 0);
    check("wb7_rbdata", rf.rbdata, 32'h77);
    check("wb7_hazard", rf.hazard, 0);

    // Same-cycle reserve and writeback on an already busy register
    rf.rsv = 1'b1; rf.rsv_addr = 5'd9;
    tick();
    idle();
    rf.rsv = 1'b1; rf.rsv_addr = 5'd9; rf.we = 1'b1; rf.waddr = 5'd9; rf.wdata = 32'h99;
    tick();
    idle();
    rf.ra = 5'd9;
    #1;
    check("rw9_radata", rf.radata, 32'h99);
    check("rw9_busy_a", rf.busy_a, 1);
    check("rw9_cnt", rf.busy_cnt, 1);
    check("rw9_err", rf.err, 0);
    rf.we = 1'b1; rf.waddr = 5'd9; rf.wdata = 32'h990;
    tick();
    idle();
    #1;
    check("wb9_cnt", rf.busy_cnt, 0);

    // Writeback to a non-busy register
    rf.we = 1'b1; rf.waddr = 5'd4; rf.wdata = 32'h55;
    tick();
    idle();
    rf.ra = 5'd4;
    #1;
    check("wr4_radata", rf.radata, 32'h55);
    check("wr4_cnt", rf.busy_cnt, 0);
    check("wr4_err", rf.err, 0);

    // Read during writeback of a busy register
    rf.rsv = 1'b1; rf.rsv_addr = 5'd4;
    tick();
    idle();
    rf.we = 1'b1; rf.waddr = 5'd4; rf.wdata = 32'h12;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check("byp_radata", rf.radata, 32'h12);
    check("byp_busy_a", rf.busy_a, 0);
`else
    check("byp_radata", rf.radata, 32'h55);
    check("byp_busy_a", rf.busy_a, 1);
`endif
    tick();
    idle();
    #1;
    check("wb4_radata", rf.radata, 32'h12);
    check("wb4_busy_a", rf.busy_a, 0);
    check("wb4_cnt", rf.busy_cnt, 0);

    // Double reservation sets sticky error; r0 reservation ignored
    rf.rsv = 1'b1; rf.rsv_addr = 5'd3;
    tick();
    #1;
    check("rsv3a_err", rf.err, 0);
    tick();
    idle();
    #1;
    check("rsv3b_err", rf.err, 1);
    check("rsv3b_cnt", rf.busy_cnt, 1);
    rf.rsv = 1'b1; rf.rsv_addr = 5'd0;
    tick();
    idle();
    rf.ra = 5'd0;
    #1;
    check("rsv0_cnt", rf.busy_cnt, 1);
    check("rsv0_busy_a", rf.busy_a, 0);

    // Reserve one register while retiring another: count holds
    rf.rsv = 1'b1; rf.rsv_addr = 5'd20; rf.we = 1'b1; rf.waddr = 5'd3; rf.wdata = 32'h3;
    tick();
    idle();
    rf.ra = 5'd20; rf.rb = 5'd3;
    #1;
    check("swap_cnt", rf.busy_cnt, 1);
    check("swap_busy_a", rf.busy_a, 1);
    check("swap_busy_b", rf.busy_b, 0);
    check("sticky_err", rf.err, 1);

    // Reset clears everything including the sticky error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst2_cnt", rf.busy_cnt, 0);
    check("rst2_err", rf.err, 0);
    check("rst2_busy_a", rf.busy_a, 0);

    // Fill every nonzero register's busy bit
    for (int i = 1; i < DEPTH; i++) begin
      rf.rsv = 1'b1; rf.rsv_addr = 5'(i);
      tick();
    end
    idle();
    rf.ra = 5'd0; rf.rb = 5'd31;
    #1;
    check("full_cnt", rf.busy_cnt, 31);
    check("full_err", rf.err, 0);
    check("full_busy_a", rf.busy_a, 0);
    check("full_busy_b", rf.busy_b, 1);

    // Reset overrides a concurrent writeback and reservation
    reset = 1'b1;
    rf.we = 1'b1; rf.waddr = 5'd12; rf.wdata = 32'hABCD;
    rf.rsv = 1'b1; rf.rsv_addr = 5'd12;
    tick();
    reset = 1'b0;
    idle();
    rf.ra = 5'd12; rf.rb = 5'd5;
    #1;
    check("rstw_cnt", rf.busy_cnt, 0);
    check("rstw_radata", rf.radata, 0);
    check("rstw_busy_a", rf.busy_a, 0);
    check("rstw_rbdata", rf.rbdata, 0);

    // First edge after reset behaves normally
    rf.we = 1'b1; rf.waddr = 5'd12; rf.wdata = 32'h1;
    rf.rsv = 1'b1; rf.rsv_addr = 5'd13;
    tick();
    idle();
    rf.rb = 5'd13;
    #1;
    check("post_radata", rf.radata, 32'h1);
    check("post_busy_b", rf.busy_b, 1);
    check("post_cnt", rf.busy_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
